// File: rtl/xgmac_cfg_pkg.sv
// Shared types and the post-reset register table for the 10G MAC/PHY
// configuration sequencer.
package xgmac_cfg_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RST  = 3'd0,
        ST_WR_ISSUE  = 3'd1,
        ST_WR_WAIT   = 3'd2,
        ST_LOCK_WAIT = 3'd3,
        ST_RUN       = 3'd4,
        ST_HOST_WAIT = 3'd5
    } cfg_state_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } cfg_entry_t;

    // Register table, executed in index order after resetdone.
    function automatic cfg_entry_t cfg_entry(input logic [3:0] idx);
        cfg_entry_t e;
        case (idx)
            4'd0:    begin e.addr = 11'h404; e.data = 32'h9000_0000; end // rx_cfg1: rx enable, FCS strip
            4'd1:    begin e.addr = 11'h408; e.data = 32'h9000_0000; end // tx_cfg: tx enable, FCS insert
            4'd2:    begin e.addr = 11'h40C; e.data = 32'h6000_0000; end // flow control rx/tx enable
            4'd3:    begin e.addr = 11'h500; e.data = 32'h0000_0068; end // mdio_cfg: MDC divider + enable
            4'd4:    begin e.addr = 11'h400; e.data = 32'h0605_0403; end // pause source MAC, low word
            4'd5:    begin e.addr = 11'h410; e.data = 32'h0800_0000; end // rs_cfg: fault inhibit
            4'd6:    begin e.addr = 11'h504; e.data = 32'h0000_0010; end // mdio_cfg1: PHY address
            4'd7:    begin e.addr = 11'h000; e.data = 32'h0000_0001; end // statistics reset
            // Spare slots, only reached when more entries are enabled.
            default: begin
                e.addr = 11'h600 | {5'd0, idx, 2'b00};
                e.data = {28'd0, idx};
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/xgmac_cfg_sync2.sv
// Two-flop synchroniser for a single level signal from another clock domain.
module xgmac_cfg_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two register stages; output follows d with two cycles of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xgmac_cfg_seq.sv
// Post-reset configuration sequencer and IPIF bus owner for the 10G MAC/PHY.
// Writes the register table once resetdone is seen, waits for sustained PCS
// block lock, then hands the bus to the runtime host port.
//
// state      | meaning
// WAIT_RST   | waiting for synchronised resetdone
// WR_ISSUE   | load table[idx] onto the bus, raise cs
// WR_WAIT    | table write in flight, waiting for wrack or timeout
// LOCK_WAIT  | table done, counting consecutive block-lock cycles
// RUN        | configured; idle bus, host requests granted here
// HOST_WAIT  | host access in flight, waiting for ack or timeout
module xgmac_cfg_seq
    import xgmac_cfg_pkg::*;
#(
    parameter int unsigned C_NUM_WR      = 8,
    parameter int unsigned C_ACK_TIMEOUT = 255,
    parameter int unsigned C_LOCK_CYCLES = 1024
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_reset,
    input  logic        resetdone,
    input  logic [7:0]  core_status,
    input  logic [31:0] ip2bus_data,
    input  logic        ip2bus_rdack,
    input  logic        ip2bus_wrack,
    input  logic        ip2bus_error,
    output logic [10:0] bus2ip_addr,
    output logic        bus2ip_cs,
    output logic        bus2ip_rnw,
    output logic [31:0] bus2ip_data,
    input  logic        host_req,
    input  logic        host_rnw,
    input  logic [10:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    output logic        host_err,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  cfg_err_idx
);

    localparam int unsigned      ACK_W    = $clog2(C_ACK_TIMEOUT + 1);
    localparam int unsigned      LOCK_W   = $clog2(C_LOCK_CYCLES + 1);
    localparam logic [3:0]       LAST_IDX = 4'(C_NUM_WR - 1);
    localparam logic [ACK_W-1:0] ACK_TC   = ACK_W'(C_ACK_TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_TC = LOCK_W'(C_LOCK_CYCLES - 1);

    cfg_state_t        state, state_nxt;
    logic [3:0]        idx, idx_nxt;
    logic [ACK_W-1:0]  ack_cnt, ack_cnt_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [10:0]       addr_nxt;
    logic [31:0]       wdata_nxt, host_rdata_nxt;
    logic              cs_nxt, rnw_nxt, host_ack_nxt, host_err_nxt;
    logic              cfg_done_nxt, cfg_error_nxt;
    logic [3:0]        err_idx_nxt;

    logic              resetdone_s, lock_s;
    logic              acc_ack, ack_tc, bus_err;
    cfg_entry_t        entry;
    logic              unused_status;

    xgmac_cfg_sync2 u_sync_resetdone (
        .clk   (bus2ip_clk),
        .reset (bus2ip_reset),
        .d     (resetdone),
        .q     (resetdone_s)
    );

    xgmac_cfg_sync2 u_sync_lock (
        .clk   (bus2ip_clk),
        .reset (bus2ip_reset),
        .d     (core_status[0]),
        .q     (lock_s)
    );

    // Only block lock matters; remaining PCS status bits are don't-care here.
    assign unused_status = ^core_status[7:1];

    assign entry = cfg_entry(idx);

    // Only the ack matching the current direction counts, and only with cs up.
    assign acc_ack = bus2ip_cs & (bus2ip_rnw ? ip2bus_rdack : ip2bus_wrack);
    assign ack_tc  = (ack_cnt == ACK_TC);
    assign bus_err = acc_ack ? ip2bus_error : 1'b1;

    // State register.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) state <= ST_WAIT_RST;
        else              state <= state_nxt;
    end

    // Next-state and next-value logic for every registered output and counter.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        ack_cnt_nxt    = ack_cnt;
        lock_cnt_nxt   = lock_cnt;
        cs_nxt         = bus2ip_cs;
        rnw_nxt        = bus2ip_rnw;
        addr_nxt       = bus2ip_addr;
        wdata_nxt      = bus2ip_data;
        host_ack_nxt   = 1'b0;
        host_rdata_nxt = host_rdata;
        host_err_nxt   = host_err;
        cfg_done_nxt   = cfg_done;
        cfg_error_nxt  = cfg_error;
        err_idx_nxt    = cfg_err_idx;

        if (!resetdone_s) begin
            // MAC/PHY went back into reset: abandon everything but the error record.
            state_nxt    = ST_WAIT_RST;
            idx_nxt      = '0;
            ack_cnt_nxt  = '0;
            lock_cnt_nxt = '0;
            cs_nxt       = 1'b0;
            cfg_done_nxt = 1'b0;
        end else begin
            case (state)
                ST_WAIT_RST: begin
                    state_nxt = ST_WR_ISSUE;
                end
                ST_WR_ISSUE: begin
                    cs_nxt      = 1'b1;
                    rnw_nxt     = 1'b0;
                    addr_nxt    = entry.addr;
                    wdata_nxt   = entry.data;
                    ack_cnt_nxt = '0;
                    state_nxt   = ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (acc_ack || ack_tc) begin
                        cs_nxt      = 1'b0;
                        ack_cnt_nxt = '0;
                        if (bus_err) begin
                            cfg_error_nxt = 1'b1;
                            if (!cfg_error) err_idx_nxt = idx;
                        end
                        idx_nxt   = idx + 4'd1;
                        state_nxt = (idx == LAST_IDX) ? ST_LOCK_WAIT : ST_WR_ISSUE;
                    end else begin
                        ack_cnt_nxt = ack_cnt + ACK_W'(1);
                    end
                end
                ST_LOCK_WAIT: begin
                    if (!lock_s) begin
                        lock_cnt_nxt = '0;
                    end else if (lock_cnt == LOCK_TC) begin
                        lock_cnt_nxt = '0;
                        cfg_done_nxt = 1'b1;
                        state_nxt    = ST_RUN;
                    end else begin
                        lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        cfg_done_nxt = 1'b0;
                        state_nxt    = ST_LOCK_WAIT;
                    end else if (host_req) begin
                        cs_nxt      = 1'b1;
                        rnw_nxt     = host_rnw;
                        addr_nxt    = host_addr;
                        wdata_nxt   = host_wdata;
                        ack_cnt_nxt = '0;
                        state_nxt   = ST_HOST_WAIT;
                    end
                end
                ST_HOST_WAIT: begin
                    if (acc_ack || ack_tc) begin
                        cs_nxt         = 1'b0;
                        ack_cnt_nxt    = '0;
                        host_ack_nxt   = 1'b1;
                        host_rdata_nxt = (bus2ip_rnw && acc_ack) ? ip2bus_data : '0;
                        host_err_nxt   = bus_err;
                        state_nxt      = ST_RUN;
                    end else begin
                        ack_cnt_nxt = ack_cnt + ACK_W'(1);
                    end
                end
                default: begin
                    cs_nxt    = 1'b0;
                    state_nxt = ST_WAIT_RST;
                end
            endcase
        end
    end

    // Registered bus, host and status outputs plus the counters.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            idx         <= '0;
            ack_cnt     <= '0;
            lock_cnt    <= '0;
            bus2ip_cs   <= 1'b0;
            bus2ip_rnw  <= 1'b0;
            bus2ip_addr <= '0;
            bus2ip_data <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_error   <= 1'b0;
            cfg_err_idx <= '0;
        end else begin
            idx         <= idx_nxt;
            ack_cnt     <= ack_cnt_nxt;
            lock_cnt    <= lock_cnt_nxt;
            bus2ip_cs   <= cs_nxt;
            bus2ip_rnw  <= rnw_nxt;
            bus2ip_addr <= addr_nxt;
            bus2ip_data <= wdata_nxt;
            host_ack    <= host_ack_nxt;
            host_rdata  <= host_rdata_nxt;
            host_err    <= host_err_nxt;
            cfg_done    <= cfg_done_nxt;
            cfg_error   <= cfg_error_nxt;
            cfg_err_idx <= err_idx_nxt;
        end
    end

endmodule

// File: tb/tb_xgmac_cfg_seq.sv
// Directed bench for xgmac_cfg_seq: table writes, timeouts, lock qualification,
// host access arbitration and reset behaviour against a behavioural IPIF slave.
`timescale 1ns/1ps
module tb_xgmac_cfg_seq;

    localparam int LOCK_CYC = 1024;
    localparam int ACK_TO   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resetdone = 1'b0;
    logic [7:0]  core_status = 8'h00;
    logic [31:0] ip2bus_data = '0;
    logic        rdack = 1'b0, wrack = 1'b0, ip_err = 1'b0;
    logic [10:0] bus2ip_addr;
    logic        bus2ip_cs, bus2ip_rnw;
    logic [31:0] bus2ip_data;
    logic        host_req = 1'b0, host_rnw = 1'b0;
    logic [10:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_ack, host_err;
    logic [31:0] host_rdata;
    logic        cfg_done, cfg_error;
    logic [3:0]  cfg_err_idx;

    always #5 clk = ~clk;

    xgmac_cfg_seq #(
        .C_NUM_WR      (8),
        .C_ACK_TIMEOUT (ACK_TO),
        .C_LOCK_CYCLES (LOCK_CYC)
    ) dut (
        .bus2ip_clk   (clk),
        .bus2ip_reset (rst),
        .resetdone    (resetdone),
        .core_status  (core_status),
        .ip2bus_data  (ip2bus_data),
        .ip2bus_rdack (rdack),
        .ip2bus_wrack (wrack),
        .ip2bus_error (ip_err),
        .bus2ip_addr  (bus2ip_addr),
        .bus2ip_cs    (bus2ip_cs),
        .bus2ip_rnw   (bus2ip_rnw),
        .bus2ip_data  (bus2ip_data),
        .host_req     (host_req),
        .host_rnw     (host_rnw),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .host_err     (host_err),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .cfg_err_idx  (cfg_err_idx)
    );

    // Hand-written copy of the expected register table.
    logic [10:0] exp_addr [8] = '{11'h404, 11'h408, 11'h40C, 11'h500,
                                  11'h400, 11'h410, 11'h504, 11'h000};
    logic [31:0] exp_data [8] = '{32'h9000_0000, 32'h9000_0000, 32'h6000_0000, 32'h0000_0068,
                                  32'h0605_0403, 32'h0800_0000, 32'h0000_0010, 32'h0000_0001};

    int n_chk = 0;
    int n_pass = 0;

    // Slave behaviour knobs and access log.
    int          ack_at = 4;
    int          stall_num = -1;
    int          err_num = -1;
    bit          stall_all = 1'b0;
    logic [31:0] rd_word = '0;
    int          stable_bad = 0;
    int          n_log = 0;
    logic [10:0] log_addr [128];
    logic [31:0] log_data [128];
    logic        log_rnw  [128];
    logic        log_done [128];
    int          log_len  [128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input string tag, input int target, input int budget);
        int i;
        i = 0;
        while (n_log < target && i < budget) begin
            tick();
            i++;
        end
        chk(tag, n_log, target);
    endtask

    task automatic wait_hack(input string tag, input int budget);
        int i;
        i = 0;
        while (host_ack !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 32'(host_ack), 1);
    endtask

    // Behavioural IPIF slave: acks on the ack_at-th cs-high cycle, logs each access.
    initial begin : slave
        int          cnt;
        logic [10:0] a;
        logic [31:0] d;
        logic        r;
        cnt = 0;
        a = '0;
        d = '0;
        r = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdack = 1'b0;
            wrack = 1'b0;
            ip_err = 1'b0;
            ip2bus_data = '0;
            if (bus2ip_cs === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    a = bus2ip_addr;
                    d = bus2ip_data;
                    r = bus2ip_rnw;
                    log_done[n_log] = cfg_done;
                end else if (bus2ip_addr !== a || bus2ip_data !== d || bus2ip_rnw !== r) begin
                    stable_bad++;
                end
                if (cnt == ack_at && !stall_all && n_log != stall_num) begin
                    if (r) begin
                        rdack = 1'b1;
                        ip2bus_data = rd_word;
                    end else begin
                        wrack = 1'b1;
                    end
                    ip_err = (n_log == err_num);
                end
            end else if (cnt > 0) begin
                log_addr[n_log] = a;
                log_data[n_log] = d;
                log_rnw[n_log]  = r;
                log_len[n_log]  = cnt;
                n_log++;
                cnt = 0;
            end
        end
    end

    initial begin : main
        int n;
        int base;

        // Reset state
        repeat (3) tick();
        chk("rst_cs", 32'(bus2ip_cs), 0);
        chk("rst_addr", 32'(bus2ip_addr), 0);
        chk("rst_data", bus2ip_data, 0);
        chk("rst_cfg_done", 32'(cfg_done), 0);
        chk("rst_cfg_error", 32'(cfg_error), 0);
        chk("rst_host_ack", 32'(host_ack), 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_no_access", n_log, 0);

        // T1: full table, slave acks on 4th cs cycle
        resetdone = 1'b1;
        wait_log("t1_count", 8, 200);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_addr%0d", i), 32'(log_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("t1_data%0d", i), log_data[i], exp_data[i]);
            chk($sformatf("t1_rnw%0d", i), 32'(log_rnw[i]), 0);
            chk($sformatf("t1_len%0d", i), log_len[i], 4);
        end
        chk("t1_cfg_error", 32'(cfg_error), 0);
        chk("t1_cfg_done", 32'(cfg_done), 0);

        // Spurious acks with cs low are ignored
        wrack = 1'b1;
        rdack = 1'b1;
        ip_err = 1'b1;
        tick();
        tick();
        chk("spur_cs", 32'(bus2ip_cs), 0);
        chk("spur_cfg_error", 32'(cfg_error), 0);
        chk("spur_no_access", n_log, 8);

        // T3: lock for 500 cycles, glitch low, then steady
        core_status = 8'h01;
        repeat (500) tick();
        chk("t3_no_early_done", 32'(cfg_done), 0);
        core_status = 8'hFE;
        repeat (3) tick();
        core_status = 8'h01;
        n = 0;
        while (cfg_done !== 1'b1 && n < 1200) begin
            tick();
            n++;
        end
        chk("t3_lock_latency", n, LOCK_CYC + 2);

        // T4: host read
        base = n_log;
        rd_word = 32'hDEAD_BEEF;
        host_rnw = 1'b1;
        host_addr = 11'h240;
        host_req = 1'b1;
        wait_hack("t4_ack", 50);
        host_req = 1'b0;
        chk("t4_rdata", host_rdata, 32'hDEAD_BEEF);
        chk("t4_err", 32'(host_err), 0);
        tick();
        chk("t4_ack_pulse", 32'(host_ack), 0);
        repeat (10) tick();
        chk("t4_one_access", n_log, base + 1);
        chk("t4_addr", 32'(log_addr[base]), 32'h240);
        chk("t4_rnw", 32'(log_rnw[base]), 1);

        // Host write answered with error
        base = n_log;
        err_num = base;
        host_rnw = 1'b0;
        host_addr = 11'h123;
        host_wdata = 32'h5555_AAAA;
        host_req = 1'b1;
        wait_hack("hw_ack", 50);
        host_req = 1'b0;
        err_num = -1;
        chk("hw_err", 32'(host_err), 1);
        chk("hw_rdata", host_rdata, 0);
        repeat (3) tick();
        chk("hw_data", log_data[base], 32'h5555_AAAA);
        chk("hw_addr", 32'(log_addr[base]), 32'h123);
        chk("hw_cfg_error", 32'(cfg_error), 0);

        // Host read that times out
        base = n_log;
        stall_num = base;
        host_rnw = 1'b1;
        host_addr = 11'h3FC;
        host_req = 1'b1;
        wait_hack("hto_ack", 400);
        host_req = 1'b0;
        stall_num = -1;
        chk("hto_err", 32'(host_err), 1);
        chk("hto_rdata", host_rdata, 0);
        repeat (3) tick();
        chk("hto_len", log_len[base], ACK_TO + 1);

        // resetdone falls while configured
        resetdone = 1'b0;
        repeat (5) tick();
        chk("rdfall_done", 32'(cfg_done), 0);

        // T2 + T5: second pass with entry 2 stalled, entry 5 error-acked, host waiting
        base = n_log;
        stall_num = base + 2;
        err_num = base + 5;
        rd_word = 32'h1234_5678;
        host_rnw = 1'b1;
        host_addr = 11'h7FC;
        host_req = 1'b1;
        resetdone = 1'b1;
        wait_log("t2_count", base + 8, 1000);
        stall_num = -1;
        err_num = -1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_addr%0d", i), 32'(log_addr[base + i]), 32'(exp_addr[i]));
            chk($sformatf("t2_data%0d", i), log_data[base + i], exp_data[i]);
            chk($sformatf("t2_rnw%0d", i), 32'(log_rnw[base + i]), 0);
            chk($sformatf("t2_len%0d", i), log_len[base + i], (i == 2) ? ACK_TO + 1 : 4);
        end
        chk("t2_cfg_error", 32'(cfg_error), 1);
        chk("t2_err_idx", 32'(cfg_err_idx), 2);
        wait_hack("t5_ack", 1200);
        host_req = 1'b0;
        chk("t5_count", n_log, base + 9);
        chk("t5_rnw", 32'(log_rnw[base + 8]), 1);
        chk("t5_addr", 32'(log_addr[base + 8]), 32'h7FC);
        chk("t5_after_done", 32'(log_done[base + 8]), 1);
        chk("t5_rdata", host_rdata, 32'h1234_5678);
        repeat (20) tick();
        chk("t5_single_grant", n_log, base + 9);
        chk("t5_done_held", 32'(cfg_done), 1);

        // Lock drop in RUN
        core_status = 8'h00;
        n = 0;
        while (cfg_done !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("lockdrop_latency", n, 3);
        core_status = 8'h01;

        // resetdone fall keeps the error record
        resetdone = 1'b0;
        repeat (5) tick();
        chk("rdfall_err_kept", 32'(cfg_error), 1);
        chk("rdfall_idx_kept", 32'(cfg_err_idx), 2);

        // T6: bus reset in the middle of a table write
        base = n_log;
        stall_all = 1'b1;
        resetdone = 1'b1;
        n = 0;
        while (bus2ip_cs !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_cs_up", 32'(bus2ip_cs), 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t6_cs_drop", 32'(bus2ip_cs), 0);
        chk("t6_addr", 32'(bus2ip_addr), 0);
        chk("t6_data", bus2ip_data, 0);
        chk("t6_cfg_error", 32'(cfg_error), 0);
        chk("t6_err_idx", 32'(cfg_err_idx), 0);
        chk("t6_host_rdata", host_rdata, 0);
        chk("t6_cfg_done", 32'(cfg_done), 0);
        rst = 1'b0;
        stall_all = 1'b0;
        wait_log("t6_count", base + 9, 300);
        chk("t6_aborted_addr", 32'(log_addr[base]), 32'h404);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_addr%0d", i), 32'(log_addr[base + 1 + i]), 32'(exp_addr[i]));
        end
        chk("t6_cfg_error_after", 32'(cfg_error), 0);

        chk("bus_stable", stable_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
